// File: rtl/project_types.sv
// Shared pipeline control types: stall vector layout, controller states and
// the default exception redirect target.
package project_types;

    typedef logic [5:0] stall_t;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    typedef enum logic {
        CTRL_IDLE  = 1'b0,
        CTRL_FLUSH = 1'b1
    } ctrl_state_t;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;

    // Holds stage `top` and everything upstream of it; the stage above `top` gets a bubble.
    function automatic stall_t stall_upto(input int top);
        stall_t s;
        s = '0;
        for (int i = STG_PC; i <= top; i++) begin
            s[i] = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Stall watchdog: saturating run-length of consecutive stalled cycles with a
// sticky timeout flag, plus a free-running stalled-cycle counter.
module stall_watchdog
    import project_types::*;
#(
    parameter int STALL_LIMIT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_active_i,
    output logic             timeout_o,
    output logic [CNT_W-1:0] total_o
);

    localparam int RUN_W = $clog2(STALL_LIMIT + 1);
    localparam logic [RUN_W-1:0] LIMIT_V = RUN_W'(STALL_LIMIT);

    logic [RUN_W-1:0] run_q, run_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] total_q, total_d;

    always_comb begin
        run_d = run_q;
        if (!stall_active_i) begin
            run_d = '0;
        end else if (run_q != LIMIT_V) begin
            run_d = run_q + 1'b1;
        end
        // The flag rises on the same edge the run reaches the limit.
        timeout_d = timeout_q | (run_d == LIMIT_V);
        total_d   = total_q + CNT_W'(stall_active_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q     <= '0;
            timeout_q <= 1'b0;
            total_q   <= '0;
        end else begin
            run_q     <= run_d;
            timeout_q <= timeout_d;
            total_q   <= total_d;
        end
    end

    assign timeout_o = timeout_q;
    assign total_o   = total_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: priority-encodes stage stall requests and
// sequences one-cycle exception/eret flushes with a redirect PC.
module pipe_ctrl
    import project_types::*;
#(
    parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF,
    parameter int          STALL_LIMIT = 16,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             excp_valid,
    input  logic             eret_valid,
    input  logic [31:0]      epc_i,
    output stall_t           stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_total,
    output ctrl_state_t      dbg_state_o
);

    ctrl_state_t state_q, state_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic        event_in;

    assign event_in = excp_valid | eret_valid;

    always_comb begin
        state_d  = state_q;
        new_pc_d = new_pc_q;
        stall    = '0;
        case (state_q)
            CTRL_IDLE: begin
                if (event_in) begin
                    state_d  = CTRL_FLUSH;
                    new_pc_d = excp_valid ? EXC_VECTOR : epc_i;
                end else if (!rst) begin
                    // Highest stage wins; requests are dropped while an event is taken.
                    if (stallreq_mem)     stall = stall_upto(STG_MEM);
                    else if (stallreq_ex) stall = stall_upto(STG_EX);
                    else if (stallreq_id) stall = stall_upto(STG_ID);
                    else if (stallreq_if) stall = stall_upto(STG_IF);
                end
            end
            CTRL_FLUSH: begin
                state_d = CTRL_IDLE;
            end
            default: state_d = CTRL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CTRL_IDLE;
            new_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            new_pc_q <= new_pc_d;
        end
    end

    assign flush       = (state_q == CTRL_FLUSH);
    assign new_pc      = new_pc_q;
    assign dbg_state_o = state_q;

    stall_watchdog #(
        .STALL_LIMIT(STALL_LIMIT),
        .CNT_W      (CNT_W)
    ) u_watchdog (
        .clk           (clk),
        .rst           (rst),
        .stall_active_i(stall != '0),
        .timeout_o     (stall_timeout),
        .total_o       (stall_total)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: encoder, flush sequencing,
// new_pc selection, watchdog and reset behaviour.
module tb_pipe_ctrl;
    import project_types::*;

    logic        clk;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        excp_valid, eret_valid;
    logic [31:0] epc_i;
    stall_t      stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [31:0] stall_total;
    ctrl_state_t dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .excp_valid   (excp_valid),
        .eret_valid   (eret_valid),
        .epc_i        (epc_i),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_timeout(stall_timeout),
        .stall_total  (stall_total),
        .dbg_state_o  (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stallreq_if  = 1'b0;
        stallreq_id  = 1'b0;
        stallreq_ex  = 1'b0;
        stallreq_mem = 1'b0;
        excp_valid   = 1'b0;
        eret_valid   = 1'b0;
        epc_i        = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        stallreq_mem = 1'b1;
        step();
        step();
        #1;
        n_checks++;
        if (stall !== 6'h00) begin
            n_fail++;
            $display("FAIL reset_stall: got %h expected 00", stall);
        end
        rst = 1'b0;
        stallreq_mem = 1'b0;
        #1;
        n_checks++;
        if (flush !== 1'b0 || new_pc !== 32'h0 || stall_timeout !== 1'b0 ||
            stall_total !== 32'h0 || dbg_state !== CTRL_IDLE) begin
            n_fail++;
            $display("FAIL reset_values: flush=%b new_pc=%h timeout=%b total=%0d state=%0d expected 0,0,0,0,0",
                     flush, new_pc, stall_timeout, stall_total, dbg_state);
        end
    endtask

    task automatic test_encoder();
        logic [3:0] req_v [5];
        stall_t     exp_v [5];
        req_v[0] = 4'b0001; exp_v[0] = 6'h03;
        req_v[1] = 4'b0010; exp_v[1] = 6'h07;
        req_v[2] = 4'b0100; exp_v[2] = 6'h0F;
        req_v[3] = 4'b1000; exp_v[3] = 6'h1F;
        req_v[4] = 4'b1010; exp_v[4] = 6'h1F;
        for (int i = 0; i < 5; i++) begin
            step();
            {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req_v[i];
            #1;
            n_checks++;
            if (stall !== exp_v[i]) begin
                n_fail++;
                $display("FAIL encoder[%0d]: req=%b got %h expected %h", i, req_v[i], stall, exp_v[i]);
            end
        end
        step();
        clear_inputs();
        #1;
        n_checks++;
        if (stall !== 6'h00) begin
            n_fail++;
            $display("FAIL encoder_none: got %h expected 00", stall);
        end
    endtask

    task automatic test_exception_flush();
        step();
        stallreq_ex = 1'b1;
        excp_valid  = 1'b1;
        #1;
        n_checks++;
        if (stall !== 6'h00) begin
            n_fail++;
            $display("FAIL excp_cycle_n_stall: got %h expected 00", stall);
        end
        step();
        excp_valid = 1'b0;
        #1;
        n_checks++;
        if (flush !== 1'b1 || new_pc !== 32'h20 || stall !== 6'h00) begin
            n_fail++;
            $display("FAIL excp_cycle_n1: flush=%b new_pc=%h stall=%h expected 1,00000020,00",
                     flush, new_pc, stall);
        end
        step();
        #1;
        n_checks++;
        if (flush !== 1'b0 || stall !== 6'h0F) begin
            n_fail++;
            $display("FAIL excp_cycle_n2: flush=%b stall=%h expected 0,0f", flush, stall);
        end
        clear_inputs();
    endtask

    task automatic test_eret_priority();
        step();
        eret_valid = 1'b1;
        epc_i      = 32'hBFC0_0100;
        step();
        eret_valid = 1'b0;
        epc_i      = 32'h1234_5678;
        #1;
        n_checks++;
        if (flush !== 1'b1 || new_pc !== 32'hBFC0_0100) begin
            n_fail++;
            $display("FAIL eret_redirect: flush=%b new_pc=%h expected 1,bfc00100", flush, new_pc);
        end
        // An event during FLUSH must be ignored.
        excp_valid = 1'b1;
        step();
        excp_valid = 1'b0;
        #1;
        n_checks++;
        if (flush !== 1'b0 || new_pc !== 32'hBFC0_0100) begin
            n_fail++;
            $display("FAIL event_in_flush: flush=%b new_pc=%h expected 0,bfc00100", flush, new_pc);
        end
        step();
        #1;
        n_checks++;
        if (flush !== 1'b0 || new_pc !== 32'hBFC0_0100) begin
            n_fail++;
            $display("FAIL new_pc_hold: flush=%b new_pc=%h expected 0,bfc00100", flush, new_pc);
        end
        eret_valid = 1'b1;
        excp_valid = 1'b1;
        epc_i      = 32'hBFC0_0100;
        step();
        clear_inputs();
        #1;
        n_checks++;
        if (flush !== 1'b1 || new_pc !== 32'h20) begin
            n_fail++;
            $display("FAIL excp_beats_eret: flush=%b new_pc=%h expected 1,00000020", flush, new_pc);
        end
        step();
    endtask

    task automatic test_watchdog();
        logic [31:0] base;
        base = stall_total;
        stallreq_mem = 1'b1;
        repeat (15) step();
        #1;
        n_checks++;
        if (stall_timeout !== 1'b0 || stall_total !== base + 32'd15) begin
            n_fail++;
            $display("FAIL wd_15: timeout=%b total=%0d expected 0,%0d", stall_timeout, stall_total, base + 15);
        end
        step();
        #1;
        n_checks++;
        if (stall_timeout !== 1'b1 || stall_total !== base + 32'd16) begin
            n_fail++;
            $display("FAIL wd_16: timeout=%b total=%0d expected 1,%0d", stall_timeout, stall_total, base + 16);
        end
        stallreq_mem = 1'b0;
        repeat (4) step();
        #1;
        n_checks++;
        if (stall_timeout !== 1'b1 || stall_total !== base + 32'd16) begin
            n_fail++;
            $display("FAIL wd_sticky: timeout=%b total=%0d expected 1,%0d", stall_timeout, stall_total, base + 16);
        end
    endtask

    task automatic test_short_runs();
        // Runs of 10 broken by idle cycles must never trip a fresh watchdog.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int r = 0; r < 3; r++) begin
            stallreq_id = 1'b1;
            repeat (10) step();
            stallreq_id = 1'b0;
            step();
        end
        #1;
        n_checks++;
        if (stall_timeout !== 1'b0 || stall_total !== 32'd30) begin
            n_fail++;
            $display("FAIL short_runs: timeout=%b total=%0d expected 0,30", stall_timeout, stall_total);
        end
    endtask

    task automatic test_reset_mid_flush();
        stallreq_if = 1'b1;
        repeat (20) step();
        stallreq_if = 1'b0;
        excp_valid  = 1'b1;
        step();
        excp_valid = 1'b0;
        rst        = 1'b1;
        #1;
        n_checks++;
        if (flush !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_flush: got %b expected 1", flush);
        end
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (flush !== 1'b0 || new_pc !== 32'h0 || stall_total !== 32'h0 ||
            stall_timeout !== 1'b0 || dbg_state !== CTRL_IDLE) begin
            n_fail++;
            $display("FAIL reset_mid_flush: flush=%b new_pc=%h total=%0d timeout=%b state=%0d expected 0,0,0,0,0",
                     flush, new_pc, stall_total, stall_timeout, dbg_state);
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_encoder();
        test_exception_flush();
        test_eret_priority();
        test_watchdog();
        test_short_runs();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline. Every pipeline register (pc, if_id, id_ex, ex_mem, mem_wb) consumes its stall vector.
- Merges per-stage stall requests into one stall vector and sequences exception/eret flushes with a redirect PC.
- Keeps a stall watchdog and a stall-cycle performance counter.

Parameters:
- EXC_VECTOR, 32'h0000_0020, redirect PC for exceptions.
- STALL_LIMIT, 16, consecutive stalled cycles before stall_timeout is raised.
- CNT_W, 32, width of the stall_total counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stallreq_if  in  1  instruction fetch not ready.
- stallreq_id  in  1  load-use hazard.
- stallreq_ex  in  1  multi-cycle EX op (div/madd) busy.
- stallreq_mem  in  1  data memory busy.
- excp_valid  in  1  exception detected in MEM, single-cycle pulse.
- eret_valid  in  1  eret reaches MEM, single-cycle pulse.
- epc_i  in  32  return address for eret.
- stall  out  6  bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
- flush  out  1  clear all pipeline registers.
- new_pc  out  32  redirect target, valid while flush=1.
- stall_timeout  out  1  sticky watchdog flag.
- stall_total  out  CNT_W  count of cycles with stall!=0.

Behaviour:
- Stall semantics used by the pipeline registers:
  - stall[n]=1 holds stage n.
  - stall[n]=1 with stall[n+1]=0 inserts a bubble into stage n+1.
- Stall encoding is combinational from the requests; the highest-stage request wins:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
  - stall[5] is always 0.
- FSM states: IDLE and FLUSH.
  - IDLE → FLUSH when excp_valid|eret_valid is sampled.
  - FLUSH → IDLE unconditionally after 1 cycle.
- Outputs per state:
  - flush=1 only in FLUSH.
  - stall is forced to 0 in FLUSH.
  - Requests are also ignored in the same cycle an event is sampled.
- Latency: flush and new_pc are registered and appear exactly 1 cycle after the event pulse.
- new_pc selection:
  - EXC_VECTOR for an exception; epc_i (sampled with eret_valid) for eret.
  - new_pc holds its last value outside FLUSH.
- Simultaneous excp_valid and eret_valid: the exception wins and new_pc=EXC_VECTOR.
- An event arriving while in FLUSH is ignored; the pipeline is being cleared.
- Watchdog:
  - stall_run counts consecutive cycles with stall!=0 and clears on any cycle with stall==0.
  - stall_run saturates at STALL_LIMIT.
  - When stall_run reaches STALL_LIMIT, stall_timeout is set and stays 1 until rst.
- Performance counter: stall_total increments on each cycle with stall!=0 and wraps modulo 2^CNT_W.
- Reset values: state=IDLE, flush=0, new_pc=0, stall_timeout=0, stall_total=0, stall_run=0. stall evaluates to 0 while rst=1.
- Reset mid-FLUSH: the next cycle is IDLE with flush=0. The pending redirect is discarded.

Decomposition:
- Shared project_types package gets:
  - stall_t (logic [5:0]).
  - Stage index constants STG_PC..STG_WB.
  - ctrl_state_t enum {CTRL_IDLE, CTRL_FLUSH}.
  - EXC_VECTOR default constant.
- One natural sub-module: stall_watchdog, covering the stall_run saturating counter, the sticky timeout flag and stall_total.
- The priority encoder and FSM stay in pipe_ctrl.

Test Plan:
- Each single request with others 0:
  - stallreq_if → stall=6'h03
  - stallreq_id → 6'h07
  - stallreq_ex → 6'h0F
  - stallreq_mem → 6'h1F
- Priority: stallreq_id=1 and stallreq_mem=1 together → stall=6'h1F.
- excp_valid pulse at cycle N while stallreq_ex=1:
  - Cycle N: stall=0.
  - Cycle N+1: flush=1, new_pc=32'h20, stall=0.
  - Cycle N+2: flush=0, stall=6'h0F.
- Simultaneous eret and exception:
  - eret_valid=1 with epc_i=32'hBFC0_0100 → next cycle new_pc=32'hBFC0_0100.
  - Repeat with excp_valid also 1 → new_pc=32'h20.
- Watchdog:
  - stallreq_mem held 15 cycles → stall_timeout=0, stall_total=15.
  - Held to 16 cycles → stall_timeout=1.
  - Drop the request → stall_timeout stays 1 until rst.
- Reset mid-operation: excp_valid at N, rst=1 at N+1 → flush=0, new_pc=0, stall_total=0 at N+2.
